// File: rtl/adt7420_i2c_responder.sv
// adt7420_i2c_responder: I2C target emulating an ADT7420 temperature sensor register file
module adt7420_i2c_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'h4B,
  parameter logic [7:0] ID_VALUE  = 8'hCB,
  parameter logic [7:0] CFG_RESET = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  input  logic [15:0] temp_i,
  output logic [7:0]  cfg_o,
  output logic        busy_o
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP} state_t;
  state_t state, state_n;
  logic [2:0] scl_q, sda_q;
  logic fall_d, scl_rise, scl_fall, start, stop;
  logic [3:0] cnt, cnt_n;
  logic [6:0] sr, sr_n;
  logic [7:0] tx, tx_n, ptr, ptr_n, cfg_n, rd_data, byte_in;
  logic [15:0] shadow, shadow_n;
  logic oe_n, busy_n, first, first_n, rw, rw_n;
  // [0]/[1] are the synchronizer stages, [2] is the history bit
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start = sda_q[2] & ~sda_q[1] & scl_q[1];
  assign stop = ~sda_q[2] & sda_q[1] & scl_q[1];
  assign byte_in = {sr, sda_q[1]};
  assign rd_data = ptr == 8'h00 ? shadow[15:8] :
                   ptr == 8'h01 ? shadow[7:0] :
                   ptr == 8'h03 ? cfg_o :
                   ptr == 8'h0B ? ID_VALUE : 8'h00;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      scl_q <= '1;
      sda_q <= '1;
      fall_d <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      tx <= '0;
      ptr <= '0;
      cfg_o <= CFG_RESET;
      shadow <= '0;
      sda_oe_o <= 1'b0;
      busy_o <= 1'b0;
      first <= 1'b0;
      rw <= 1'b0;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
      fall_d <= scl_fall;
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      tx <= tx_n;
      ptr <= ptr_n;
      cfg_o <= cfg_n;
      shadow <= shadow_n;
      sda_oe_o <= oe_n;
      busy_o <= busy_n;
      first <= first_n;
      rw <= rw_n;
    end
  // SDA drive only moves on fall_d, so it never changes while SCL is high
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    tx_n = tx;
    ptr_n = ptr;
    cfg_n = cfg_o;
    shadow_n = shadow;
    oe_n = sda_oe_o;
    busy_n = busy_o;
    first_n = first;
    rw_n = rw;
    if (start) begin
      state_n = ADDR;
      cnt_n = '0;
      shadow_n = temp_i;
      oe_n = 1'b0;
      busy_n = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      oe_n = 1'b0;
      busy_n = 1'b0;
    end else
      case (state)
        ADDR:
          if (scl_rise) begin
            sr_n = byte_in[6:0];
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              state_n = byte_in[7:1] == DEV_ADDR ? ADDR_ACK : WAIT_STOP;
              busy_n = byte_in[7:1] == DEV_ADDR;
              rw_n = byte_in[0];
            end
          end
        ADDR_ACK:
          if (fall_d) begin
            if (!sda_oe_o)
              oe_n = 1'b1;
            else if (rw) begin
              state_n = RD_BYTE;
              oe_n = ~rd_data[7];
              tx_n = {rd_data[6:0], 1'b0};
              cnt_n = 4'd1;
            end else begin
              state_n = WR_BYTE;
              oe_n = 1'b0;
              first_n = 1'b1;
              cnt_n = '0;
            end
          end
        WR_BYTE:
          if (scl_rise) begin
            sr_n = byte_in[6:0];
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              state_n = WR_ACK;
              cnt_n = '0;
              first_n = 1'b0;
              ptr_n = first ? byte_in : ptr + 8'd1;
              cfg_n = !first && ptr == 8'h03 ? byte_in : cfg_o;
            end
          end
        WR_ACK:
          if (fall_d) begin
            oe_n = ~sda_oe_o;
            state_n = sda_oe_o ? WR_BYTE : WR_ACK;
          end
        RD_BYTE:
          if (fall_d) begin
            if (cnt == 4'd8) begin
              oe_n = 1'b0;
              ptr_n = ptr + 8'd1;
              state_n = RD_ACK;
            end else begin
              oe_n = ~tx[7];
              tx_n = {tx[6:0], 1'b0};
              cnt_n = cnt + 4'd1;
            end
          end
        RD_ACK:
          if (scl_rise) begin
            state_n = sda_q[1] ? WAIT_STOP : RD_BYTE;
            tx_n = rd_data;
            cnt_n = '0;
          end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_adt7420_i2c_responder.sv
// tb_adt7420_i2c_responder: directed I2C master driving the ADT7420 responder
module tb_adt7420_i2c_responder;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
  logic sda_line, sda_oe, busy;
  logic [15:0] temp = 16'h0000;
  logic [7:0] cfg, rd;
  logic ack;
  int total = 0, bad = 0;

  assign sda_line = m_sda & ~sda_oe;

  adt7420_i2c_responder dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_i(sda_line),
    .sda_oe_o(sda_oe), .temp_i(temp), .cfg_o(cfg), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic quarter;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; quarter();
    scl = 1'b1; quarter();
    m_sda = 1'b0; quarter();
    scl = 1'b0; quarter();
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; quarter();
    scl = 1'b1; quarter();
    m_sda = 1'b1; quarter();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; quarter();
    scl = 1'b1; quarter(); quarter();
    scl = 1'b0; quarter();
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; quarter();
    scl = 1'b1; quarter();
    b = sda_line; quarter();
    scl = 1'b0; quarter();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(a);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(nack);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check("reset_oe", {7'd0, sda_oe}, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'h00);
    check("reset_cfg", cfg, 8'h00);
    rst = 1'b0;
    quarter();

    // ID read through pointer write + repeated START
    i2c_start();
    write_byte(8'h96, ack); check("id_addr_w_ack", {7'd0, ack}, 8'h00);
    check("id_busy", {7'd0, busy}, 8'h01);
    write_byte(8'h0B, ack); check("id_ptr_ack", {7'd0, ack}, 8'h00);
    i2c_start();
    write_byte(8'h97, ack); check("id_addr_r_ack", {7'd0, ack}, 8'h00);
    read_byte(1'b1, rd); check("id_value", rd, 8'hCB);
    check("id_released", {7'd0, sda_oe}, 8'h00);
    i2c_stop();
    check("id_busy_after_stop", {7'd0, busy}, 8'h00);

    // temperature read with consistent MSB/LSB
    temp = 16'h0C80;
    i2c_start();
    write_byte(8'h96, ack); check("temp_addr_ack", {7'd0, ack}, 8'h00);
    write_byte(8'h00, ack); check("temp_ptr_ack", {7'd0, ack}, 8'h00);
    i2c_start();
    write_byte(8'h97, ack);
    read_byte(1'b0, rd); check("temp_msb", rd, 8'h0C);
    temp = 16'h1234;
    read_byte(1'b1, rd); check("temp_lsb_shadowed", rd, 8'h80);
    i2c_stop();

    // foreign address is ignored
    i2c_start();
    write_byte(8'h90, ack); check("other_addr_nack", {7'd0, ack}, 8'h01);
    check("other_busy", {7'd0, busy}, 8'h00);
    write_byte(8'h00, ack); check("other_still_passive", {7'd0, ack}, 8'h01);
    i2c_stop();

    // config write then read back
    i2c_start();
    write_byte(8'h96, ack);
    write_byte(8'h03, ack);
    write_byte(8'h80, ack); check("cfg_data_ack", {7'd0, ack}, 8'h00);
    check("cfg_written", cfg, 8'h80);
    i2c_stop();
    i2c_start();
    write_byte(8'h96, ack);
    write_byte(8'h03, ack);
    i2c_start();
    write_byte(8'h97, ack);
    read_byte(1'b1, rd); check("cfg_readback", rd, 8'h80);
    i2c_stop();

    // pointer wrap 0xFF -> 0x00
    i2c_start();
    write_byte(8'h96, ack);
    write_byte(8'hFF, ack);
    i2c_start();
    write_byte(8'h97, ack);
    read_byte(1'b0, rd); check("wrap_ff", rd, 8'h00);
    read_byte(1'b1, rd); check("wrap_00", rd, 8'h12);
    i2c_stop();

    // reset in the middle of a read byte (0x12: bit 3 is 0, so SDA is pulled)
    i2c_start();
    write_byte(8'h96, ack);
    write_byte(8'h00, ack);
    i2c_start();
    write_byte(8'h97, ack);
    for (int i = 0; i < 4; i++) recv_bit(rd[7 - i]);
    check("mid_read_bits", {4'd0, rd[7:4]}, 8'h01);
    check("mid_read_driving", {7'd0, sda_oe}, 8'h01);
    rst = 1'b1;
    #1;
    check("rst_releases_sda", {7'd0, sda_oe}, 8'h00);
    check("rst_cfg", cfg, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    quarter();
    rst = 1'b0;
    quarter();
    i2c_stop();
    i2c_start();
    write_byte(8'h97, ack); check("post_rst_ack", {7'd0, ack}, 8'h00);
    read_byte(1'b1, rd); check("post_rst_ptr0", rd, 8'h12);
    i2c_stop();
    check("final_idle_oe", {7'd0, sda_oe}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adt7420_i2c_responder.md
# adt7420_i2c_responder

I2C target that emulates the on-board ADT7420 temperature sensor (7-bit address 0x4B) as seen by the temperature-sensor I2C master inside the SoC. It oversamples the SCL/SDA lines on the system clock, decodes START/STOP/address/data, and answers register reads from a temperature value supplied on a port. It replaces the physical sensor in board-less simulation and in loop-back builds, where the master's SCL/SDA pins connect to this block instead of the pads.

## Interface

- DEV_ADDR, 7'h4B, 7-bit I2C target address.
- ID_VALUE, 8'hCB, value returned at register 0x0B.
- CFG_RESET, 8'h00, reset value of config register 0x03.

- clk_i  in  1  system clock, 100 MHz; must be ≥ 20× SCL frequency.
- rst_i  in  1  asynchronous, active-high reset.
- scl_i  in  1  SCL line level, asynchronous, never driven by this block.
- sda_i  in  1  SDA line level, asynchronous.
- sda_oe_o  out  1  1 = pull SDA low (open-drain); 0 = release.
- temp_i  in  16  emulated temperature, ADT7420 13-bit format, MSB first.
- cfg_o  out  8  current config register.
- busy_o  out  1  high from an address match until STOP or a new START.

## Operation

- Input conditioning: scl_i/sda_i pass through 2-FF synchronizers plus one history FF; rise/fall of SCL and SDA are single-cycle pulses from synced vs history.
- START = SDA fall while synced SCL high; STOP = SDA rise while SCL high. Both are recognised in every state and take priority over any bit event in the same cycle.
- On START: temp_i latched into a 16-bit shadow (MSB/LSB of one read are consistent); bit counter cleared; go to ADDR. On STOP: go to IDLE, release SDA, busy_o low.
- Bits are sampled on SCL rise; sda_oe_o changes only on the cycle after an SCL fall (never while SCL is high).
- States:
  - IDLE: sda_oe_o 0; waits for START.
  - ADDR: shift 8 bits MSB first. Match to DEV_ADDR → ADDR_ACK, busy_o 1; else WAIT_STOP.
  - ADDR_ACK: drive low for the 9th clock. R/W=0 → WR_BYTE, first-byte flag set; R/W=1 → load the byte at the pointer, go to RD_BYTE.
  - WR_BYTE: shift 8 bits. With the first-byte flag set, the byte loads the pointer. Otherwise it writes the register at the pointer (only 0x03 is writable; others are ignored), then the pointer increments. Then WR_ACK.
  - WR_ACK: drive low for the 9th clock; back to WR_BYTE.
  - RD_BYTE: on each SCL fall, present the next bit (drive low for 0, release for 1), MSB first. After the 8th bit, release SDA and the pointer increments; go to RD_ACK.
  - RD_ACK: sample the master bit at SCL rise. ACK (0) → load the next byte, go to RD_BYTE. NACK (1) → WAIT_STOP with SDA released.
  - WAIT_STOP: passive until START or STOP.
- Register map, 8-bit pointer:
  - 0x00: shadow[15:8]
  - 0x01: shadow[7:0]
  - 0x02: 0x00
  - 0x03: cfg
  - 0x0B: ID_VALUE
  - all others: 0x00
- Pointer wraps 0xFF → 0x00. The pointer persists across transactions (a write-pointer then repeated-START read works).
- No clock stretching and no general-call support.

## Timing

- Reset values: sda_oe_o 0, busy_o 0, cfg_o CFG_RESET, pointer 0x00, state IDLE, shadow 0.
- rst_i asserted mid-transfer releases SDA immediately (asynchronously); the block ignores the bus until the next START.
- Pin-to-detect latency: 3 clk_i cycles. SCL fall to sda_oe_o update: 4 cycles. This is well inside the low period when clk_i ≥ 20× SCL.
- Config write: cfg_o updates 1 cycle after the SCL rise that samples bit 0 of the data byte.
- A repeated START in any state aborts the current byte; partial write bytes are discarded.

## Test plan

- Write to 0x96 (addr 0x4B, W), data 0x0B; repeated START; send 0x97, read 1 byte with NACK → all ACK slots low, byte read = 0xCB, SDA released afterwards.
- temp_i=16'h0C80; write pointer 0x00; read 2 bytes with ACK then NACK → 0x0C, 0x80. Change temp_i to 16'h1234 mid-read → second byte still 0x80.
- Address 0x90 (addr 0x48) → sda_oe_o stays 0 through the 9th clock, busy_o stays 0, no state change until STOP.
- Write 0x96, 0x03, 0x80 → cfg_o = 0x80; then read from pointer 0x03 → 0x80.
- Write pointer 0xFF; read 2 bytes → 0x00, then byte at 0x00 (temp MSB), confirming the pointer wrap.
- Assert rst_i during bit 3 of a read byte → sda_oe_o 0 the same cycle, cfg_o = CFG_RESET. A new transaction after reset reads pointer 0x00.
